// File: rtl/risc_v_ex_mem_wb.sv
// RV32I back end: ID/EX register, execute, EX/MEM register, data memory and
// MEM/WB register. Also holds operand forwarding, load-use stall detection
// and the two-slot branch squash.
module risc_v_ex_mem_wb #(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_ID,
  input  logic [31:0] IMM_ID,
  input  logic [31:0] REG_DATA1_ID,
  input  logic [31:0] REG_DATA2_ID,
  input  logic [2:0]  FUNCT3_ID,
  input  logic [6:0]  FUNCT7_ID,
  input  logic [6:0]  OPCODE_ID,
  input  logic [4:0]  RD_ID,
  input  logic [4:0]  RS1_ID,
  input  logic [4:0]  RS2_ID,
  output logic        PCSrc,
  output logic [31:0] PC_Branch,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        RegWrite_WB,
  output logic [31:0] ALU_DATA_WB,
  output logic [4:0]  RD_WB
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DMEM_WORDS);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Integer ALU shared by OP and OP-IMM; shift amount is always b[4:0].
  function automatic logic [DATA_W-1:0] alu_f(
    input logic [2:0]        f3,
    input logic              alt_sub,
    input logic              alt_sra,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [4:0]               sh;
    sa = a;
    sb = b;
    sh = b[4:0];
    case (f3)
      3'b000:  alu_f = alt_sub ? (a - b) : (a + b);
      3'b001:  alu_f = a << sh;
      3'b010:  alu_f = {{(DATA_W-1){1'b0}}, (sa < sb)};
      3'b011:  alu_f = {{(DATA_W-1){1'b0}}, (a < b)};
      3'b100:  alu_f = a ^ b;
      3'b101:  alu_f = alt_sra ? $unsigned(sa >>> sh) : (a >> sh);
      3'b110:  alu_f = a | b;
      default: alu_f = a & b;
    endcase
  endfunction

  // Branch condition; 010/011 are never passed in (filtered as bubbles).
  function automatic logic br_taken_f(
    input logic [2:0]        f3,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  br_taken_f = (a == b);
      3'b001:  br_taken_f = (a != b);
      3'b100:  br_taken_f = (sa < sb);
      3'b101:  br_taken_f = (sa >= sb);
      3'b110:  br_taken_f = (a < b);
      3'b111:  br_taken_f = (a >= b);
      default: br_taken_f = 1'b0;
    endcase
  endfunction

  // ID/EX (_p0)
  logic              vld_p0;
  logic [DATA_W-1:0] pc_p0, imm_p0, rs1_data_p0, rs2_data_p0;
  logic [2:0]        funct3_p0;
  logic              alt_p0;
  logic [6:0]        opcode_p0;
  logic [4:0]        rd_p0, rs1_p0, rs2_p0;
  logic              kill;

  // EX/MEM (_p1)
  logic              vld_p1, reg_write_p1, load_p1, store_p1;
  logic [DATA_W-1:0] alu_p1, store_data_p1;
  logic [4:0]        rd_p1;

  // MEM/WB (_p2)
  logic              vld_p2, reg_write_p2;
  logic [DATA_W-1:0] data_p2;
  logic [4:0]        rd_p2;

  logic [DATA_W-1:0] dmem [DMEM_WORDS];
  logic [AW-1:0]     dmem_idx;
  logic [DATA_W-1:0] mem_rdata, mem_fwd;

  logic              is_op, is_opi, is_load, is_store, is_branch, reg_write_ex;
  logic [DATA_W-1:0] op_a, op_b, alu_res;
  logic              branch_taken, stall, bubble_id;
  logic              id_fwd1, id_fwd2;
  logic              unused_funct7;

  assign unused_funct7 = ^{FUNCT7_ID[6], FUNCT7_ID[4:0]};

  // ID-side control: capture forwarding from WB, load-use stall, bubble select
  always_comb begin
    id_fwd1   = RegWrite_WB && (RD_WB != 5'd0) && (RD_WB == RS1_ID);
    id_fwd2   = RegWrite_WB && (RD_WB != 5'd0) && (RD_WB == RS2_ID);
    stall     = vld_p0 && is_load && (rd_p0 != 5'd0) &&
                ((rd_p0 == RS1_ID) || (rd_p0 == RS2_ID));
    bubble_id = stall || branch_taken || kill;
  end

  // ID/EX register; a bubble only drops the valid bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0      <= 1'b0;
      kill        <= 1'b0;
      pc_p0       <= '0;
      imm_p0      <= '0;
      rs1_data_p0 <= '0;
      rs2_data_p0 <= '0;
      funct3_p0   <= '0;
      alt_p0      <= 1'b0;
      opcode_p0   <= '0;
      rd_p0       <= '0;
      rs1_p0      <= '0;
      rs2_p0      <= '0;
    end else begin
      vld_p0      <= !bubble_id;
      kill        <= branch_taken;
      pc_p0       <= PC_ID;
      imm_p0      <= IMM_ID;
      rs1_data_p0 <= id_fwd1 ? ALU_DATA_WB : REG_DATA1_ID;
      rs2_data_p0 <= id_fwd2 ? ALU_DATA_WB : REG_DATA2_ID;
      funct3_p0   <= FUNCT3_ID;
      alt_p0      <= FUNCT7_ID[5];
      opcode_p0   <= OPCODE_ID;
      rd_p0       <= RD_ID;
      rs1_p0      <= RS1_ID;
      rs2_p0      <= RS2_ID;
    end
  end

  // EX: decode, operand forwarding (EX/MEM before MEM/WB), ALU and branch
  always_comb begin
    is_op        = (opcode_p0 == OPC_OP);
    is_opi       = (opcode_p0 == OPC_OP_IMM);
    is_load      = (opcode_p0 == OPC_LOAD)  && (funct3_p0 == 3'b010);
    is_store     = (opcode_p0 == OPC_STORE) && (funct3_p0 == 3'b010);
    is_branch    = (opcode_p0 == OPC_BRANCH) && (funct3_p0[2:1] != 2'b01);
    reg_write_ex = vld_p0 && (is_op || is_opi || is_load) && (rd_p0 != 5'd0);

    op_a = rs1_data_p0;
    if (vld_p1 && reg_write_p1 && (rd_p1 == rs1_p0))
      op_a = mem_fwd;
    else if (vld_p2 && reg_write_p2 && (rd_p2 == rs1_p0))
      op_a = data_p2;

    op_b = rs2_data_p0;
    if (vld_p1 && reg_write_p1 && (rd_p1 == rs2_p0))
      op_b = mem_fwd;
    else if (vld_p2 && reg_write_p2 && (rd_p2 == rs2_p0))
      op_b = data_p2;

    // sub only exists for register-register; OP-IMM funct7 bits are imm.
    if (is_op)
      alu_res = alu_f(funct3_p0, alt_p0, alt_p0, op_a, op_b);
    else if (is_opi)
      alu_res = alu_f(funct3_p0, 1'b0, alt_p0, op_a, imm_p0);
    else
      alu_res = op_a + imm_p0;

    branch_taken = vld_p0 && is_branch && br_taken_f(funct3_p0, op_a, op_b);
  end

  // EX/MEM register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1        <= 1'b0;
      reg_write_p1  <= 1'b0;
      load_p1       <= 1'b0;
      store_p1      <= 1'b0;
      alu_p1        <= '0;
      store_data_p1 <= '0;
      rd_p1         <= '0;
    end else begin
      vld_p1        <= vld_p0;
      reg_write_p1  <= reg_write_ex;
      load_p1       <= vld_p0 && is_load;
      store_p1      <= vld_p0 && is_store;
      alu_p1        <= alu_res;
      store_data_p1 <= op_b;
      rd_p1         <= rd_p0;
    end
  end

  // MEM: word-addressed memory, combinational read
  assign dmem_idx  = alu_p1[AW+1:2];
  assign mem_rdata = dmem[dmem_idx];
  assign mem_fwd   = load_p1 ? mem_rdata : alu_p1;

  // Store write; vld_p1 is cleared asynchronously so reset blocks the write
  always_ff @(posedge clk) begin
    if (vld_p1 && store_p1)
      dmem[dmem_idx] <= store_data_p1;
  end

  // MEM/WB register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2       <= 1'b0;
      reg_write_p2 <= 1'b0;
      data_p2      <= '0;
      rd_p2        <= '0;
    end else begin
      vld_p2       <= vld_p1;
      reg_write_p2 <= vld_p1 && reg_write_p1;
      data_p2      <= mem_fwd;
      rd_p2        <= rd_p1;
    end
  end

  assign RegWrite_WB = vld_p2 && reg_write_p2;
  assign ALU_DATA_WB = data_p2;
  assign RD_WB       = rd_p2;
  assign PCSrc       = branch_taken;
  assign PC_Branch   = pc_p0 + imm_p0;
  assign PC_write    = !stall;
  assign IF_ID_write = !stall;

endmodule

// File: tb/tb_risc_v_ex_mem_wb.sv
// Directed bench for risc_v_ex_mem_wb: a table of single-instruction vectors
// followed by hand-written multi-instruction sequences.
module tb_risc_v_ex_mem_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID;
  logic [2:0]  FUNCT3_ID;
  logic [6:0]  FUNCT7_ID, OPCODE_ID;
  logic [4:0]  RD_ID, RS1_ID, RS2_ID;
  logic        PCSrc, PC_write, IF_ID_write, RegWrite_WB;
  logic [31:0] PC_Branch, ALU_DATA_WB;
  logic [4:0]  RD_WB;

  always #5 clk = ~clk;

  risc_v_ex_mem_wb #(.DMEM_WORDS(256)) dut (
    .clk(clk), .reset(reset),
    .PC_ID(PC_ID), .IMM_ID(IMM_ID),
    .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID),
    .FUNCT3_ID(FUNCT3_ID), .FUNCT7_ID(FUNCT7_ID), .OPCODE_ID(OPCODE_ID),
    .RD_ID(RD_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .PCSrc(PCSrc), .PC_Branch(PC_Branch),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .RegWrite_WB(RegWrite_WB), .ALU_DATA_WB(ALU_DATA_WB), .RD_WB(RD_WB)
  );

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, pc;
  } inst_t;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm, a, b, pc;
    logic        we;
    logic [31:0] data;
    logic        br;
    logic [31:0] pcb;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          stalls_pc = 0;
  int          stalls_if = 0;
  logic [31:0] rf [32];
  logic        exp_set  [128];
  logic        exp_we   [128];
  logic [4:0]  exp_rd   [128];
  logic [31:0] exp_data [128];

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic inst_t r_type(input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [4:0] rd, rs1, rs2);
    return '{7'h33, f3, f7, rd, rs1, rs2, 32'd0, 32'd0};
  endfunction

  function automatic inst_t i_type(input logic [2:0] f3, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [31:0] imm);
    return '{7'h13, f3, imm[11:5], rd, rs1, imm[4:0], imm, 32'd0};
  endfunction

  function automatic inst_t lw(input logic [4:0] rd, rs1, input logic [31:0] imm);
    return '{7'h03, 3'd2, imm[11:5], rd, rs1, imm[4:0], imm, 32'd0};
  endfunction

  function automatic inst_t sw(input logic [4:0] rs2, rs1, input logic [31:0] imm);
    return '{7'h23, 3'd2, imm[11:5], imm[4:0], rs1, rs2, imm, 32'd0};
  endfunction

  function automatic inst_t b_type(input logic [2:0] f3, input logic [4:0] rs1, rs2,
                                   input logic [31:0] imm, input logic [31:0] pc);
    return '{7'h63, f3, imm[11:5], imm[4:0], rs1, rs2, imm, pc};
  endfunction

  function automatic vec_t mkv(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm, a, b, pc,
                               input logic we, input logic [31:0] data,
                               input logic br, input logic [31:0] pcb);
    return '{op, f3, f7, imm, a, b, pc, we, data, br, pcb};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic present(input inst_t i);
    PC_ID        = i.pc;
    IMM_ID       = i.imm;
    REG_DATA1_ID = rf[i.rs1];
    REG_DATA2_ID = rf[i.rs2];
    FUNCT3_ID    = i.f3;
    FUNCT7_ID    = i.f7;
    OPCODE_ID    = i.op;
    RD_ID        = i.rd;
    RS1_ID       = i.rs1;
    RS2_ID       = i.rs2;
  endtask

  // One clock: register-file model commits the WB triple at the edge.
  task automatic step();
    logic        w;
    logic [4:0]  r;
    logic [31:0] d;
    w = RegWrite_WB;
    r = RD_WB;
    d = ALU_DATA_WB;
    @(posedge clk);
    #1;
    if (w && r != 5'd0) rf[r] = d;
    cyc++;
    if (cyc < 128 && exp_set[cyc]) begin
      exp_set[cyc] = 1'b0;
      chk($sformatf("wb_we_c%0d", cyc), {31'd0, RegWrite_WB}, {31'd0, exp_we[cyc]});
      if (exp_we[cyc]) begin
        chk($sformatf("wb_rd_c%0d", cyc), {27'd0, RD_WB}, {27'd0, exp_rd[cyc]});
        chk($sformatf("wb_data_c%0d", cyc), ALU_DATA_WB, exp_data[cyc]);
      end
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 128; k++) exp_set[k] = 1'b0;
    cyc = 0;
  endtask

  // Present an instruction, re-presenting it while the back end holds IF/ID.
  task automatic issue(input inst_t i, input logic ew, input logic [4:0] erd,
                       input logic [31:0] ed);
    logic held;
    int   tries;
    tries = 0;
    do begin
      present(i);
      #1;
      held = !IF_ID_write;
      if (!PC_write)    stalls_pc++;
      if (!IF_ID_write) stalls_if++;
      step();
      tries++;
    end while (held && tries < 4);
    if (held) chk("stall_bound", 32'd1, 32'd0);
    if (cyc + 2 < 128) begin
      exp_set[cyc+2]  = 1'b1;
      exp_we[cyc+2]   = ew;
      exp_rd[cyc+2]   = erd;
      exp_data[cyc+2] = ed;
    end
  endtask

  task automatic idle(input int n);
    present('0);
    repeat (n) step();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_regwrite"}, {31'd0, RegWrite_WB}, 32'd0);
    chk({tag, "_aludata"},  ALU_DATA_WB, 32'd0);
    chk({tag, "_rd"},       {27'd0, RD_WB}, 32'd0);
    chk({tag, "_pcsrc"},    {31'd0, PCSrc}, 32'd0);
    chk({tag, "_pcbranch"}, PC_Branch, 32'd0);
    chk({tag, "_pcwrite"},  {31'd0, PC_write}, 32'd1);
    chk({tag, "_ifidwrite"},{31'd0, IF_ID_write}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vecs[0]  = mkv(7'h33, 3'd0, 7'h00, 0, 32'd5, 32'd7, 0, 1, 32'd12, 0, 0);
    vecs[1]  = mkv(7'h33, 3'd0, 7'h20, 0, 32'd5, 32'd7, 0, 1, 32'hFFFFFFFE, 0, 0);
    vecs[2]  = mkv(7'h33, 3'd1, 7'h00, 0, 32'd1, 32'h3F, 0, 1, 32'h80000000, 0, 0);
    vecs[3]  = mkv(7'h33, 3'd2, 7'h00, 0, 32'hFFFFFFFF, 32'd1, 0, 1, 32'd1, 0, 0);
    vecs[4]  = mkv(7'h33, 3'd3, 7'h00, 0, 32'hFFFFFFFF, 32'd1, 0, 1, 32'd0, 0, 0);
    vecs[5]  = mkv(7'h33, 3'd4, 7'h00, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 1, 32'h0FF00FF0, 0, 0);
    vecs[6]  = mkv(7'h33, 3'd5, 7'h00, 0, 32'h80000000, 32'd4, 0, 1, 32'h08000000, 0, 0);
    vecs[7]  = mkv(7'h33, 3'd5, 7'h20, 0, 32'h80000000, 32'd4, 0, 1, 32'hF8000000, 0, 0);
    vecs[8]  = mkv(7'h33, 3'd6, 7'h00, 0, 32'hF0F0F0F0, 32'h0F0F0000, 0, 1, 32'hFFFFF0F0, 0, 0);
    vecs[9]  = mkv(7'h33, 3'd7, 7'h00, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 1, 32'hF000F000, 0, 0);
    vecs[10] = mkv(7'h13, 3'd0, 7'h7F, 32'hFFFFFFFD, 32'd10, 32'd0, 0, 1, 32'd7, 0, 0);
    vecs[11] = mkv(7'h13, 3'd5, 7'h20, 32'h00000404, 32'h80000000, 32'd0, 0, 1, 32'hF8000000, 0, 0);
    vecs[12] = mkv(7'h13, 3'd5, 7'h00, 32'd4, 32'h80000000, 32'd0, 0, 1, 32'h08000000, 0, 0);
    vecs[13] = mkv(7'h13, 3'd2, 7'h7F, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 0, 1, 32'd1, 0, 0);
    vecs[14] = mkv(7'h13, 3'd3, 7'h7F, 32'hFFFFFFFF, 32'd1, 32'd0, 0, 1, 32'd1, 0, 0);
    vecs[15] = mkv(7'h63, 3'd0, 7'h00, 32'h10, 32'd3, 32'd3, 32'h20, 0, 0, 1, 32'h30);
    vecs[16] = mkv(7'h63, 3'd1, 7'h00, 32'h10, 32'd3, 32'd3, 32'h20, 0, 0, 0, 0);
    vecs[17] = mkv(7'h63, 3'd4, 7'h7F, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'd1, 32'h100, 0, 0, 1, 32'hF0);
    vecs[18] = mkv(7'h63, 3'd5, 7'h00, 32'd8, 32'd1, 32'hFFFFFFFF, 32'h40, 0, 0, 1, 32'h48);
    vecs[19] = mkv(7'h63, 3'd6, 7'h00, 32'd8, 32'hFFFFFFFF, 32'd1, 32'h40, 0, 0, 0, 0);
    vecs[20] = mkv(7'h63, 3'd7, 7'h00, 32'd4, 32'hFFFFFFFF, 32'd1, 32'h0, 0, 0, 1, 32'h4);
    vecs[21] = mkv(7'h63, 3'd2, 7'h00, 32'd8, 32'd3, 32'd3, 32'h40, 0, 0, 0, 0);
    vecs[22] = mkv(7'h03, 3'd0, 7'h00, 32'd8, 32'd0, 32'd0, 0, 0, 0, 0, 0);
    vecs[23] = mkv(7'h7F, 3'd0, 7'h00, 32'd0, 32'd5, 32'd7, 0, 0, 0, 0, 0);

    for (int k = 0; k < 32; k++) rf[k] = 32'd0;
    clear_exp();

    // Reset with a live-looking instruction on the ID inputs
    reset = 1'b1;
    present(i_type(3'd0, 5'd1, 5'd0, 32'd5));
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset("rst_init");
    reset = 1'b0;
    idle(1);

    // Table: one instruction, then two bubbles; PCSrc in EX, WB two edges later
    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      PC_ID = v.pc;  IMM_ID = v.imm;
      REG_DATA1_ID = v.a;  REG_DATA2_ID = v.b;
      FUNCT3_ID = v.f3;  FUNCT7_ID = v.f7;  OPCODE_ID = v.op;
      RD_ID = 5'd10;  RS1_ID = 5'd20;  RS2_ID = 5'd21;
      step();
      chk($sformatf("vec%0d_pcsrc", k), {31'd0, PCSrc}, {31'd0, v.br});
      if (v.br) chk($sformatf("vec%0d_pcbranch", k), PC_Branch, v.pcb);
      present('0);
      step();
      step();
      chk($sformatf("vec%0d_regwrite", k), {31'd0, RegWrite_WB}, {31'd0, v.we});
      if (v.we) begin
        chk($sformatf("vec%0d_data", k), ALU_DATA_WB, v.data);
        chk($sformatf("vec%0d_rd", k), {27'd0, RD_WB}, 32'd10);
      end
    end

    // Stale register-file contents, so only forwarded values can be right
    for (int k = 1; k < 32; k++) rf[k] = 32'hBAD00000 + k;
    clear_exp();
    stalls_pc = 0;
    stalls_if = 0;

    // Back-to-back dependent ALU ops
    issue(i_type(3'd0, 5'd1, 5'd0, 32'd5), 1'b1, 5'd1, 32'd5);
    issue(i_type(3'd0, 5'd2, 5'd0, 32'd7), 1'b1, 5'd2, 32'd7);
    issue(r_type(3'd0, 7'h00, 5'd3, 5'd1, 5'd2), 1'b1, 5'd3, 32'd12);
    chk("alu_chain_pc_write_stalls", stalls_pc, 32'd0);

    // Store, load, then load-use
    issue(sw(5'd3, 5'd0, 32'd8), 1'b0, 5'd0, 32'd0);
    issue(lw(5'd4, 5'd0, 32'd8), 1'b1, 5'd4, 32'd12);
    issue(r_type(3'd0, 7'h00, 5'd5, 5'd4, 5'd4), 1'b1, 5'd5, 32'd24);
    chk("load_use_pc_write_stalls", stalls_pc, 32'd1);
    chk("load_use_if_id_stalls", stalls_if, 32'd1);
    idle(3);

    // Taken beq squashes two following instructions
    issue(b_type(3'd0, 5'd1, 5'd1, 32'd16, 32'h20), 1'b0, 5'd0, 32'd0);
    chk("beq_pcsrc", {31'd0, PCSrc}, 32'd1);
    chk("beq_pcbranch", PC_Branch, 32'h30);
    issue(i_type(3'd0, 5'd7, 5'd0, 32'd1), 1'b0, 5'd0, 32'd0);
    chk("beq_pcsrc_one_cycle", {31'd0, PCSrc}, 32'd0);
    issue(i_type(3'd0, 5'd8, 5'd0, 32'd2), 1'b0, 5'd0, 32'd0);
    issue(b_type(3'd1, 5'd1, 5'd1, 32'd8, 32'h30), 1'b0, 5'd0, 32'd0);
    chk("bne_pcsrc", {31'd0, PCSrc}, 32'd0);

    // Signed vs unsigned compare on forwarded operands
    issue(i_type(3'd0, 5'd9, 5'd0, 32'hFFFFFFFF), 1'b1, 5'd9, 32'hFFFFFFFF);
    issue(i_type(3'd0, 5'd10, 5'd0, 32'd1), 1'b1, 5'd10, 32'd1);
    issue(b_type(3'd6, 5'd9, 5'd10, 32'd8, 32'h40), 1'b0, 5'd0, 32'd0);
    chk("bltu_pcsrc", {31'd0, PCSrc}, 32'd0);
    issue(b_type(3'd4, 5'd9, 5'd10, 32'd8, 32'h50), 1'b0, 5'd0, 32'd0);
    chk("blt_pcsrc", {31'd0, PCSrc}, 32'd1);
    chk("blt_pcbranch", PC_Branch, 32'h58);
    issue('0, 1'b0, 5'd0, 32'd0);
    issue('0, 1'b0, 5'd0, 32'd0);

    // x0 destination
    issue(i_type(3'd0, 5'd0, 5'd0, 32'd9), 1'b0, 5'd0, 32'd0);
    issue(r_type(3'd0, 7'h00, 5'd6, 5'd0, 5'd0), 1'b1, 5'd6, 32'd0);
    idle(3);

    // Reset while a store is in EX: the old memory word must survive
    issue(sw(5'd1, 5'd0, 32'd12), 1'b0, 5'd0, 32'd0);
    idle(3);
    issue(i_type(3'd0, 5'd11, 5'd0, 32'h55), 1'b1, 5'd11, 32'h55);
    issue(sw(5'd11, 5'd0, 32'd12), 1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    #1;
    check_reset("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_exp();
    issue(lw(5'd12, 5'd0, 32'd12), 1'b1, 5'd12, 32'd5);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_v_ex_mem_wb.md
Name: risc_v_ex_mem_wb

Overview:
Back-end pipeline for the five-stage RV32I core: ID/EX register, execute, EX/MEM register, data memory, MEM/WB register. Consumes the decode-stage bundle from the fetch/decode front end. Returns the branch redirect (PCSrc, PC_Branch), the hazard controls (PC_write, IF_ID_write) and the write-back triple (RegWrite_WB, ALU_DATA_WB, RD_WB). Contains forwarding, load-use stall and branch squash logic.

Parameters:
DMEM_WORDS, 256, data memory depth in 32-bit words; address index = ALU result[log2(DMEM_WORDS)+1:2]

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
PC_ID  input  32  PC of the instruction in ID
IMM_ID  input  32  sign-extended immediate
REG_DATA1_ID  input  32  rs1 register-file data
REG_DATA2_ID  input  32  rs2 register-file data
FUNCT3_ID  input  3  funct3
FUNCT7_ID  input  7  funct7
OPCODE_ID  input  7  opcode
RD_ID  input  5  destination register
RS1_ID  input  5  source register 1
RS2_ID  input  5  source register 2
PCSrc  output  1  branch taken in EX; redirects fetch
PC_Branch  output  32  branch target = PC_EX + IMM_EX
PC_write  output  1  0 = hold PC (load-use stall)
IF_ID_write  output  1  0 = hold IF/ID (load-use stall)
RegWrite_WB  output  1  register-file write enable, registered
ALU_DATA_WB  output  32  write-back data (ALU result or load data), registered
RD_WB  output  5  write-back destination, registered

Behaviour:
- Supported instructions:
  - OP 0110011: add, sub, sll, slt, sltu, xor, srl, sra, or, and; funct7[5] selects sub/sra.
  - OP-IMM 0010011: the same operations with IMM_ID; shamt = IMM[4:0].
  - LOAD 0000011: funct3=010 (lw) only.
  - STORE 0100011: funct3=010 (sw) only.
  - BRANCH 1100011: beq, bne, blt, bge, bltu, bgeu.
  - Anything else, and unsupported funct3 on load/store/branch, is a bubble: no reg write, no mem write, no branch.
- Pipeline registers: ID/EX, EX/MEM, MEM/WB, each carrying a valid bit. Reset clears all valid bits and all data fields to 0.
- Reset values: RegWrite_WB=0, ALU_DATA_WB=0, RD_WB=0, PCSrc=0, PC_Branch=0, PC_write=1, IF_ID_write=1, kill flag=0. Data memory is not reset.
- Latency: instruction sampled from ID at edge n. It executes in cycle n+1, is in MEM in cycle n+2, and its WB outputs are valid in cycle n+3.
- Writes to x0: RegWrite forced 0 when RD=0.
- ID capture forwarding: if RegWrite_WB and RD_WB≠0 and RD_WB matches RS1_ID/RS2_ID, ID/EX latches ALU_DATA_WB instead of the register-file data.
- EX forwarding, per operand, highest priority first:
  1. EX/MEM, if valid, RegWrite and RD match. Value is the ALU result, or the memory read data when the EX/MEM instruction is a load.
  2. MEM/WB, if valid, RegWrite and RD match.
  3. ID/EX latched data.
- Data memory: combinational read in MEM; write on clk edge when a valid sw is in MEM. Address bits [1:0] ignored.
- Load-use stall: combinational. Condition: a valid lw is in ID/EX, RD_EX≠0, and RD_EX equals RS1_ID or RS2_ID. Response:
  - PC_write=0 and IF_ID_write=0.
  - At the next edge ID/EX loads a bubble.
  - Exactly one stall cycle per hazard.
- Branch: resolved in EX; PCSrc and PC_Branch are combinational from ID/EX. When PCSrc=1:
  - At the edge, ID/EX loads a bubble (squashes the instruction in ID).
  - The kill flag is set, so the next edge also loads a bubble (squashes the wrong-path instruction fetched during the branch cycle).
  - The kill flag clears after one use.
- Stall and branch are mutually exclusive, since EX holds a load or a branch, never both.
- Reset mid-operation flushes everything immediately. No stores complete after reset asserts.
- Arithmetic: 32-bit wrap-around; slt/blt/bge signed; sltu/bltu/bgeu unsigned.

Test Plan:
- Reset asserted mid-stream while a sw is in EX -> all outputs at reset values immediately; memory word unchanged after release.
- addi x1,x0,5; addi x2,x0,7; add x3,x1,x2 back-to-back -> RD_WB=3, ALU_DATA_WB=12 three cycles after add enters ID; no stall (PC_write stays 1).
- sw x3,8(x0) then lw x4,8(x0); add x5,x4,x4 -> exactly one cycle PC_write=IF_ID_write=0; x4=12, x5=24 on WB.
- beq x1,x1,+16 at PC 0x20 -> PCSrc=1 for one cycle with PC_Branch=0x30; the next two instructions from ID never raise RegWrite_WB.
- bne x1,x1 (not taken) and bltu with 0xFFFFFFFF vs 1 -> PCSrc=0 in both cases; blt with the same operands -> PCSrc=1.
- addi x0,x0,9 then add x6,x0,x0 -> RegWrite_WB=0 for the x0 write; x6 result 0.
